fpdiv_vector_checker: RTL
=========================

// Module: fpdiv_vector_checker
// PURPOSE
// Synthesizable self-checking vector engine for the fpdiv/fpsqrt datapath.
// Fetches packed {dividend, divisor, expected, flags} vectors from a synchronous-read vector memory.
// Issues each vector to a multi-cycle divider through a start/done handshake and compares the result.
// Accumulates pass/fail counts and captures the first failure. Runs on silicon/FPGA and in sim alike.
// Generalised over operand width, vector depth, op (div/sqrt) and rounding mode (rne/rz).
// PARAMETERS
// WIDTH    32  operand/result width (32 = f32, 64 = f64)
// ADDR_W   10  vector memory address width; max 2**ADDR_W vectors
// FLAG_W   2   trailing flag field per vector (carried, not compared)
// TIMEOUT  64  max cycles from dut_start to dut_done before a vector is declared failed
// PORTS
// clk              in   1                  clock, all logic posedge
// reset            in   1                  synchronous, active-high
// start            in   1                  begin a run (accepted only in IDLE/FINISH)
// op               in   2                  00=div 01=sqrt; sampled at start acceptance
// round_mode       in   1                  0=rne 1=rz; sampled at start acceptance
// skip_zero        in   1                  1: vectors with dividend==0 are skipped (not counted)
// num_vectors      in   ADDR_W+1           vectors in this run; sampled at start acceptance
// vec_addr         out  ADDR_W             vector memory read address
// vec_data         in   3*WIDTH+FLAG_W     {a, b, expected, flags}, valid 1 cycle after vec_addr
// dut_start        out  1                  one-cycle pulse, issues dut_a/dut_b
// dut_a, dut_b     out  WIDTH              operands, held stable from dut_start until dut_done
// dut_op           out  2                  registered copy of op
// dut_rm           out  1                  registered copy of round_mode
// dut_done         in   1                  DUT result valid this cycle
// dut_result       in   WIDTH              DUT result
// busy             out  1                  run in progress
// done             out  1                  run complete, held until next start or reset
// pass_count       out  ADDR_W+1           vectors matching expected
// fail_count       out  ADDR_W+1           vectors mismatching or timed out
// first_fail_idx   out  ADDR_W             index of first failing vector
// first_fail_got   out  WIDTH              dut_result of first failure (0 on timeout)
// first_fail_vld   out  1                  first_fail_* captured
// timeout_err      out  1                  sticky: at least one vector timed out this run
// BEHAVIOUR
// - Reset: state=IDLE; every output 0; index and timer cleared. Reset mid-run aborts immediately.
// - FSM: IDLE -start-> FETCH -> WAIT_RD -> ISSUE -> WAIT_DUT -> CHECK -> (FETCH | FINISH).
//   FINISH -start-> FETCH. Start while busy is ignored.
// - Start acceptance: clears counters, first_fail_*, timeout_err and index; latches op/round_mode/num_vectors.
//   num_vectors==0 goes directly to FINISH with zero counts.
// - FETCH: vec_addr=index. WAIT_RD: vec_data sampled into operand/expected regs.
//   skip_zero && a==0: index++ and go to FETCH or FINISH, without issuing.
// - ISSUE: dut_start=1 for exactly one cycle. dut_done is not sampled in the ISSUE cycle.
// - WAIT_DUT: timer counts from 1; dut_done=1 -> CHECK with result latched.
//   timer==TIMEOUT without done -> CHECK marked failed, timeout_err=1.
// - CHECK: pass iff result === expected (all WIDTH bits; flags ignored). Increments pass or fail.
//   On first fail, captures idx/got and sets first_fail_vld. Then index++;
//   index==num_vectors -> FINISH else FETCH.
// - Min per-vector latency with DUT done-latency L: L+4 cycles.
// - busy=1 in all states except IDLE/FINISH. done=1 only in FINISH. Counters never wrap (width covers max).
// - dut_done outside WAIT_DUT is ignored.
// TESTING
// - f32 div rne, 1 vector 3F800000/40000000 exp 3F000000, good DUT -> pass=1 fail=0 done=1.
// - 4 vectors, vector 2 expected corrupted (40400000 vs DUT 40400001) -> pass=3 fail=1 first_fail_idx=2 got=40400001.
// - DUT never asserts done, TIMEOUT=64 -> fail after exactly 64 WAIT_DUT cycles, timeout_err=1, run still completes.
// - skip_zero=1 with vectors {00000000,..},{3F800000,3F800000 exp 3F800000} -> pass=1 fail=0, one dut_start pulse.
// - num_vectors=0 -> done next cycle after start, counts 0, no dut_start.
// - reset asserted during WAIT_DUT of vector 3 -> next cycle all outputs 0, IDLE; fresh start reruns from index 0.

Source files
------------

// File: rtl/fpdiv_vector_checker_if.sv
// Vector-memory read port plus the start/done handshake to the divider under test.
// The checker drives through the master modport; memory and divider sit on the slave side.
interface fpdiv_vector_checker_if #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 10,
  parameter int FLAG_W = 2
);
  logic [ADDR_W-1:0]         vec_addr;
  logic [3*WIDTH+FLAG_W-1:0] vec_data;
  logic                      dut_start;
  logic [WIDTH-1:0]          dut_a;
  logic [WIDTH-1:0]          dut_b;
  logic [1:0]                dut_op;
  logic                      dut_rm;
  logic                      dut_done;
  logic [WIDTH-1:0]          dut_result;

  modport master (
    output vec_addr, dut_start, dut_a, dut_b, dut_op, dut_rm,
    input  vec_data, dut_done, dut_result
  );

  modport slave (
    input  vec_addr, dut_start, dut_a, dut_b, dut_op, dut_rm,
    output vec_data, dut_done, dut_result
  );
endinterface

// File: rtl/fpdiv_vector_checker.sv
// Self-checking vector engine for the fpdiv/fpsqrt datapath.
// Walks a synchronous-read vector memory, issues each {a, b} pair to the divider,
// compares the result with the stored expected value and keeps pass/fail statistics
// together with the first failing vector.
module fpdiv_vector_checker #(
  parameter int WIDTH   = 32,
  parameter int ADDR_W  = 10,
  parameter int FLAG_W  = 2,
  parameter int TIMEOUT = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [1:0]             op,
  input  logic                   round_mode,
  input  logic                   skip_zero,
  input  logic [ADDR_W:0]        num_vectors,
  fpdiv_vector_checker_if.master vec,
  output logic                   busy,
  output logic                   done,
  output logic [ADDR_W:0]        pass_count,
  output logic [ADDR_W:0]        fail_count,
  output logic [ADDR_W-1:0]      first_fail_idx,
  output logic [WIDTH-1:0]       first_fail_got,
  output logic                   first_fail_vld,
  output logic                   timeout_err
);
  localparam int TMR_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_WAIT_RD, S_ISSUE, S_WAIT_DUT, S_CHECK, S_FINISH
  } state_t;

  state_t           state, state_nxt;
  logic [ADDR_W:0]  index;
  logic [ADDR_W:0]  idx_inc;
  logic [ADDR_W:0]  num_q;
  logic [TMR_W-1:0] timer;
  logic             tmo_q;
  logic [WIDTH-1:0] exp_q;
  logic [WIDTH-1:0] res_q;
  logic [WIDTH-1:0] rd_a, rd_b, rd_exp;
  logic             unused_flags;
  logic             idx_last;
  logic             skip_hit;
  logic             tmr_exp;
  logic             vec_ok;

  // Counters are sized for the largest run, so saturation is only a guard.
  function automatic logic [ADDR_W:0] sat_inc(input logic [ADDR_W:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Memory word layout is {a, b, expected, flags}; flags ride along unchecked.
  assign rd_a         = vec.vec_data[3*WIDTH+FLAG_W-1 -: WIDTH];
  assign rd_b         = vec.vec_data[2*WIDTH+FLAG_W-1 -: WIDTH];
  assign rd_exp       = vec.vec_data[WIDTH+FLAG_W-1 -: WIDTH];
  assign unused_flags = ^vec.vec_data[FLAG_W-1:0];

  assign idx_inc  = index + 1'b1;
  assign idx_last = (idx_inc == num_q);
  assign skip_hit = skip_zero && (rd_a == '0);
  assign tmr_exp  = (timer == TMR_W'(TIMEOUT));
  assign vec_ok   = !tmo_q && (res_q == exp_q);

  // State register; reset aborts any run in progress.
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic and state-decoded outputs.
  always_comb begin
    state_nxt     = state;
    busy          = 1'b1;
    done          = 1'b0;
    vec.dut_start = 1'b0;
    vec.vec_addr  = index[ADDR_W-1:0];
    case (state)
      S_IDLE, S_FINISH: begin
        busy = 1'b0;
        done = (state == S_FINISH);
        if (start) state_nxt = (num_vectors == '0) ? S_FINISH : S_FETCH;
      end
      S_FETCH:   state_nxt = S_WAIT_RD;
      S_WAIT_RD: begin
        if (skip_hit) state_nxt = idx_last ? S_FINISH : S_FETCH;
        else          state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        vec.dut_start = 1'b1;
        state_nxt     = S_WAIT_DUT;
      end
      S_WAIT_DUT: if (vec.dut_done || tmr_exp) state_nxt = S_CHECK;
      S_CHECK:    state_nxt = idx_last ? S_FINISH : S_FETCH;
      default:    state_nxt = S_IDLE;
    endcase
  end

  // Run control: index, timeout timer, counters and first-failure capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      index          <= '0;
      num_q          <= '0;
      timer          <= '0;
      tmo_q          <= 1'b0;
      pass_count     <= '0;
      fail_count     <= '0;
      first_fail_idx <= '0;
      first_fail_got <= '0;
      first_fail_vld <= 1'b0;
      timeout_err    <= 1'b0;
      vec.dut_op     <= '0;
      vec.dut_rm     <= 1'b0;
      vec.dut_a      <= '0;
      vec.dut_b      <= '0;
    end else begin
      case (state)
        S_IDLE, S_FINISH: begin
          if (start) begin
            index          <= '0;
            num_q          <= num_vectors;
            vec.dut_op     <= op;
            vec.dut_rm     <= round_mode;
            pass_count     <= '0;
            fail_count     <= '0;
            first_fail_idx <= '0;
            first_fail_got <= '0;
            first_fail_vld <= 1'b0;
            timeout_err    <= 1'b0;
          end
        end
        S_WAIT_RD: begin
          vec.dut_a <= rd_a;
          vec.dut_b <= rd_b;
          if (skip_hit) index <= idx_inc;
        end
        S_ISSUE: begin
          timer <= TMR_W'(1);
          tmo_q <= 1'b0;
        end
        S_WAIT_DUT: begin
          if (!vec.dut_done) begin
            if (tmr_exp) begin
              tmo_q       <= 1'b1;
              timeout_err <= 1'b1;
            end else begin
              timer <= timer + 1'b1;
            end
          end
        end
        S_CHECK: begin
          if (vec_ok) begin
            pass_count <= sat_inc(pass_count);
          end else begin
            fail_count <= sat_inc(fail_count);
            if (!first_fail_vld) begin
              first_fail_idx <= index[ADDR_W-1:0];
              first_fail_got <= res_q;
              first_fail_vld <= 1'b1;
            end
          end
          index <= idx_inc;
        end
        default: ;
      endcase
    end
  end

  // Expected value and DUT result holding registers; a timeout records a zero result.
  always_ff @(posedge clk) begin
    if (state == S_WAIT_RD) exp_q <= rd_exp;
    if (state == S_WAIT_DUT) begin
      if (vec.dut_done)  res_q <= vec.dut_result;
      else if (tmr_exp)  res_q <= '0;
    end
  end
endmodule
